y86_fetch_unit: RTL and testbench
=================================

Name: y86_fetch_unit

Overview:
- Multi-cycle instruction fetch for the sequential Y86-64 core.
- Replaces the direct array indexing of instruction memory with a byte-wide, synchronous-read instruction memory port.
- Accepts a PC, reads only the bytes the instruction needs (1, 2, 9 or 10), and presents icode/ifun plus the 72-bit byte field to split/align/decode with a valid/ready handshake.
- Also produces valP and a Y86 status code.

Parameters:
- IMEM_BYTES, 2048, instruction memory size in bytes; legal addresses are 0..IMEM_BYTES-1.
- ADDR_W, 64, PC and valP width.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  64  fetch address, sampled when pc_valid && pc_ready.
- pc_valid  in  1  fetch request.
- pc_ready  out  1  unit idle and able to accept a PC.
- flush  in  1  abort any in-flight or held fetch.
- mem_rd  out  1  instruction memory byte read strobe.
- mem_addr  out  64  byte address; data returns one cycle later.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- out_valid  out  1  fetched instruction available.
- out_ready  in  1  consumer accepts the instruction.
- ibyte  out  8  byte 0 ({icode,ifun}).
- ibytes  out  72  bytes 1..9: byte1 in [71:64] down to byte9 in [7:0]; unfetched bytes are 0.
- valP  out  64  pc + instruction length.
- need_regids  out  1  instruction has a register byte.
- need_valC  out  1  instruction has an 8-byte constant.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.

Behaviour:
- Reset (synchronous, active-high): state IDLE; pc_ready=1; mem_rd=0; mem_addr=0; out_valid=0; ibyte, ibytes, valP=0; need_regids=0, need_valC=0; stat=AOK. Reset dominates flush and all handshakes, including mid-fetch.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: pc_ready=1. On pc_valid, latch pc, clear ibytes, set count k=0, go to FETCH.
  - FETCH: pc_ready=0.
  - HOLD: out_valid=1; outputs stable until out_ready, then go to IDLE.
- Fetch timing (acceptance in cycle A):
  - Byte k is issued in cycle A+1+k (mem_rd=1, mem_addr=pc+k).
  - Byte k is captured at the end of cycle A+2+k.
  - Issues are back-to-back.
- Length N is decoded combinationally from mem_rdata while byte 0 returns (cycle A+2), before byte 1 is issued:
  - icode 0, 1, 9 → N=1
  - icode 2, 6, A, B → N=2
  - icode 7, 8 → N=9
  - icode 3, 4, 5 → N=10
  - icode C..F → INS, N=1
- Consequences:
  - Issue of byte 1 in A+2 is gated by N>1.
  - A 1-byte instruction issues exactly one read.
  - No byte ≥ N is ever issued.
  - out_valid rises in cycle A+2+N, i.e. 3 cycles for N=1 and 12 for N=10.
- valP = pc+N (64-bit wrap). need_regids and need_valC come from the same table.
- stat:
  - HLT for icode 0.
  - INS for an invalid icode.
  - ADR if any byte pc+k with k<N falls at or above IMEM_BYTES. That byte is not issued, fetch ends immediately, remaining bytes stay 0, and valP=pc+N.
  - ADR on byte 0 gives icode/ifun=0 and N=1.
  - ADR takes priority over INS and HLT.
- flush:
  - In FETCH or HOLD: next state is IDLE, out_valid drops next cycle, in-flight read data is ignored, and mem_rd is deasserted in the flush cycle.
  - In IDLE: the flush cycle's pc_valid is not accepted.
- Simultaneous out_valid && out_ready && flush: treated as flush; the handshake is not counted.
- The internal pc+k adder is 64-bit. k counter is 4 bits (0..10).

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT..POPQ).
  - stat codes (STAT_AOK/HLT/ADR/INS).
  - FSM state typedef.
- Sub-module y86_ilen: combinational, icode → {nbytes[3:0], need_regids, need_valC, ins_err}. It is reused by the existing need_block.

Test Plan:
1. Memory at 0x0 = 30 F2 0A 00 00 00 00 00 00 00, pc=0 → out_valid in A+12; ibyte=0x30; ibytes[71:56]=F20A; valP=0x0A; need_regids=1, need_valC=1; stat=AOK; exactly 10 mem_rd pulses.
2. 0x10 = 20 12 (rrmovq) → ibytes=0x12 followed by 64 zero bits; valP=0x12; 2 reads. 0x20 = 00 → stat=HLT, valP=0x21, 1 read, out_valid at A+3.
3. 0x30 = F0 → stat=INS, valP=0x31, 1 read. pc=0x7FC with 0x7FC=30 → stat=ADR, no mem_addr ≥ 0x800 ever driven.
4. Backpressure: out_ready held low 5 cycles after out_valid → ibyte, ibytes, valP and stat constant, pc_ready=0; release → pc_ready=1 next cycle.
5. Flush asserted in cycle A+5 of a 10-byte fetch → mem_rd=0 that cycle, IDLE next cycle, out_valid never rises. A new pc=0x10 then completes correctly with valP=0x12.
6. Reset asserted mid-fetch (A+4) → all outputs at reset values next cycle. A subsequent fetch of 0x20 yields stat=HLT.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Shared Y86-64 icode, status and fetch FSM definitions
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD
  } fetch_state_t;

endpackage

// File: rtl/y86_fetch_unit_if.sv
// rtl/y86_fetch_unit_if.sv - Request, instruction memory and result bundle of the fetch unit
interface y86_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        ibyte;
  logic [71:0]       ibytes;
  logic [ADDR_W-1:0] valP;
  logic              need_regids;
  logic              need_valC;
  logic [2:0]        stat;

  // Fetch unit side
  modport master (
    input  pc, pc_valid, flush, mem_rdata, out_ready,
    output pc_ready, mem_rd, mem_addr, out_valid, ibyte, ibytes, valP,
           need_regids, need_valC, stat
  );

  // Surrounding core / memory side
  modport slave (
    output pc, pc_valid, flush, mem_rdata, out_ready,
    input  pc_ready, mem_rd, mem_addr, out_valid, ibyte, ibytes, valP,
           need_regids, need_valC, stat
  );
endinterface

// File: rtl/y86_ilen.sv
// rtl/y86_ilen.sv - Y86-64 instruction length and field-presence decode
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] nbytes,
  output logic       need_regids,
  output logic       need_valC,
  output logic       ins_err
);

  // Invalid icodes are treated as 1-byte so fetch stops after byte 0
  always_comb begin
    nbytes      = 4'd1;
    need_regids = 1'b0;
    need_valC   = 1'b0;
    ins_err     = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET: nbytes = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
        nbytes      = 4'd2;
        need_regids = 1'b1;
      end
      I_JXX, I_CALL: begin
        nbytes    = 4'd9;
        need_valC = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        nbytes      = 4'd10;
        need_regids = 1'b1;
        need_valC   = 1'b1;
      end
      default: ins_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// rtl/y86_fetch_unit.sv - Multi-cycle byte-wide Y86-64 instruction fetch
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 2048,
  parameter int ADDR_W     = 64
) (
  input  logic             clk,
  input  logic             reset,
  y86_fetch_unit_if.master bus
);

  localparam logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(IMEM_BYTES);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] valp_q;
  logic [3:0]        k_q;        // next byte index to issue
  logic              pend_q;     // byte k_q-1 returns this cycle
  logic [7:0]        ibyte_q;
  logic [71:0]       ibytes_q;
  logic              regids_q;
  logic              valc_q;
  logic [2:0]        stat_q;

  logic              cap0;
  logic [7:0]        byte0_cur;
  logic [3:0]        n_cur;
  logic              len_regids;
  logic              len_valc;
  logic              len_ins;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_want;
  logic              issue_ok;
  logic              accept;
  logic              issue;
  logic              done;
  logic              adr;

  // While byte 0 is returning, decode length straight from the memory data
  assign cap0      = pend_q && (k_q == 4'd1);
  assign byte0_cur = cap0 ? bus.mem_rdata : ibyte_q;

  y86_ilen u_ilen (
    .icode       (byte0_cur[7:4]),
    .nbytes      (n_cur),
    .need_regids (len_regids),
    .need_valC   (len_valc),
    .ins_err     (len_ins)
  );

  assign issue_addr = pc_q + ADDR_W'(k_q);
  assign issue_want = (k_q < n_cur);
  assign issue_ok   = (issue_addr < IMEM_LIMIT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus issue/done decisions; flush wins over everything but reset
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    adr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.pc_valid && !bus.flush) begin
          accept  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (issue_want && issue_ok) begin
          issue = 1'b1;
        end else begin
          done    = 1'b1;
          adr     = issue_want;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.flush || bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, byte capture and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      valp_q   <= '0;
      k_q      <= 4'd0;
      pend_q   <= 1'b0;
      ibyte_q  <= 8'h00;
      ibytes_q <= 72'h0;
      regids_q <= 1'b0;
      valc_q   <= 1'b0;
      stat_q   <= STAT_AOK;
    end else if (accept) begin
      pc_q     <= bus.pc;
      k_q      <= 4'd0;
      pend_q   <= 1'b0;
      ibyte_q  <= 8'h00;
      ibytes_q <= 72'h0;
    end else if (state_q == ST_FETCH && !bus.flush) begin
      pend_q <= issue;
      if (issue) k_q <= k_q + 4'd1;
      if (pend_q) begin
        if (cap0) ibyte_q <= bus.mem_rdata;
        for (int j = 1; j <= 9; j++) begin
          if (k_q == 4'(j + 1)) ibytes_q[8*(9-j) +: 8] <= bus.mem_rdata;
        end
      end
      if (done) begin
        valp_q   <= pc_q + ADDR_W'(n_cur);
        regids_q <= len_regids;
        valc_q   <= len_valc;
        if (adr)                             stat_q <= STAT_ADR;
        else if (len_ins)                    stat_q <= STAT_INS;
        else if (byte0_cur[7:4] == I_HALT)   stat_q <= STAT_HLT;
        else                                 stat_q <= STAT_AOK;
      end
    end
  end

  assign bus.pc_ready    = (state_q == ST_IDLE);
  assign bus.mem_rd      = issue;
  assign bus.mem_addr    = issue ? issue_addr : '0;
  assign bus.out_valid   = (state_q == ST_HOLD);
  assign bus.ibyte       = ibyte_q;
  assign bus.ibytes      = ibytes_q;
  assign bus.valP        = valp_q;
  assign bus.need_regids = regids_q;
  assign bus.need_valC   = valc_q;
  assign bus.stat        = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// tb/tb_y86_fetch_unit.sv - Randomized model-checked bench for y86_fetch_unit
module tb_y86_fetch_unit;

  logic clk;
  logic reset;

  y86_fetch_unit_if #(.ADDR_W(64)) bus ();

  y86_fetch_unit #(.IMEM_BYTES(2048), .ADDR_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_cnt = 0;

  logic [7:0] mem [0:2047];

  int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  localparam logic [15:0] REGIDS_SET = 16'h0C7C;
  localparam logic [15:0] VALC_SET   = 16'h01B8;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory; garbage when not reading
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= mem[bus.mem_addr[10:0]];
      rd_cnt <= rd_cnt + 1;
    end else begin
      bus.mem_rdata <= 8'($urandom);
    end
  end

  // Behavioural model: phase 0 idle, 1 fetching, 2 holding result
  int          m_phase = 0;
  bit          m_live = 0;
  int          m_t;
  int          m_e;
  logic [63:0] m_pc;
  logic [7:0]  e_ibyte;
  logic [71:0] e_ibytes;
  logic [63:0] e_valp;
  logic        e_regids, e_valc;
  logic [2:0]  e_stat;

  task automatic model_accept(input logic [63:0] p);
    int n;
    logic [7:0] b0;
    bit stop;
    m_pc = p;
    b0 = (p < 64'd2048) ? mem[11'(p)] : 8'h00;
    n = len_tab[b0[7:4]];
    m_e = 0;
    stop = 0;
    for (int k = 0; k < n; k++) begin
      if (!stop && (p + 64'(k)) < 64'd2048) m_e++;
      else stop = 1;
    end
    e_ibyte = b0;
    e_ibytes = 72'h0;
    for (int j = 1; j < m_e; j++) e_ibytes[8*(9-j) +: 8] = mem[11'(p + 64'(j))];
    e_valp = p + 64'(n);
    e_regids = REGIDS_SET[b0[7:4]];
    e_valc = VALC_SET[b0[7:4]];
    if (m_e < n)           e_stat = 3'd3;
    else if (b0[7:4] >= 4'hC) e_stat = 3'd4;
    else if (b0[7:4] == 4'h0) e_stat = 3'd2;
    else                   e_stat = 3'd1;
  endtask

  // Compare every cycle against the model, then advance the model
  always @(negedge clk) begin
    logic exp_rd;
    if (m_live) begin
      exp_rd = (m_phase == 1) && !bus.flush && (m_t >= 1) && (m_t <= m_e);
      chk("pc_ready", 72'(bus.pc_ready), 72'(m_phase == 0));
      chk("mem_rd", 72'(bus.mem_rd), 72'(exp_rd));
      if (exp_rd) chk("mem_addr", 72'(bus.mem_addr), 72'(m_pc + 64'(m_t - 1)));
      chk("out_valid", 72'(bus.out_valid), 72'(m_phase == 2));
      if (m_phase == 2) begin
        chk("ibyte", 72'(bus.ibyte), 72'(e_ibyte));
        chk("ibytes", bus.ibytes, e_ibytes);
        chk("valP", 72'(bus.valP), 72'(e_valp));
        chk("need_regids", 72'(bus.need_regids), 72'(e_regids));
        chk("need_valC", 72'(bus.need_valC), 72'(e_valc));
        chk("stat", 72'(bus.stat), 72'(e_stat));
      end
    end
    if (reset) begin
      m_live = 1;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (bus.pc_valid && !bus.flush) begin
             model_accept(bus.pc);
             m_phase = 1;
             m_t = 1;
           end
        1: if (bus.flush) m_phase = 0;
           else begin
             m_t++;
             if (m_t == m_e + 2) m_phase = 2;
           end
        2: if (bus.flush || bus.out_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  logic [7:0]  s_ibyte;
  logic [71:0] s_ibytes;
  logic [63:0] s_valp;
  logic        s_regids, s_valc;
  logic [2:0]  s_stat;

  task automatic fetch_directed(input logic [63:0] p, input int hold, output int lat, output int nrd);
    int c, r0;
    bit seen;
    @(posedge clk); #1;
    chk("pc_ready_pre", 72'(bus.pc_ready), 72'd1);
    bus.pc = p;
    bus.pc_valid = 1'b1;
    bus.out_ready = 1'b0;
    c = cyc;
    r0 = rd_cnt;
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1;
        lat = cyc - c;
        s_ibyte = bus.ibyte;
        s_ibytes = bus.ibytes;
        s_valp = bus.valP;
        s_regids = bus.need_regids;
        s_valc = bus.need_valC;
        s_stat = bus.stat;
      end
    end
    if (!seen) chk("out_valid_timeout", 72'd0, 72'd1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    nrd = rd_cnt - r0;
  endtask

  task automatic check_reset_vals();
    chk("rst_pc_ready", 72'(bus.pc_ready), 72'd1);
    chk("rst_mem_rd", 72'(bus.mem_rd), 72'd0);
    chk("rst_mem_addr", 72'(bus.mem_addr), 72'd0);
    chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_ibyte", 72'(bus.ibyte), 72'd0);
    chk("rst_ibytes", bus.ibytes, 72'd0);
    chk("rst_valP", 72'(bus.valP), 72'd0);
    chk("rst_need_regids", 72'(bus.need_regids), 72'd0);
    chk("rst_need_valC", 72'(bus.need_valC), 72'd0);
    chk("rst_stat", 72'(bus.stat), 72'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nrd, r;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'h20; mem[16'h11] = 8'h12;
    mem[16'h20] = 8'h00;
    mem[16'h30] = 8'hF0;
    mem[16'h7FC] = 8'h30; mem[16'h7FD] = 8'hF2; mem[16'h7FE] = 8'hAB; mem[16'h7FF] = 8'hCD;

    reset = 1'b1;
    bus.pc = 64'h0;
    bus.pc_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals();

    // irmovq, 10 bytes
    fetch_directed(64'h0, 0, lat, nrd);
    chk("t1_lat", 72'(lat), 72'd12);
    chk("t1_nrd", 72'(nrd), 72'd10);
    chk("t1_ibyte", 72'(s_ibyte), 72'h30);
    chk("t1_ibytes_hi", 72'(s_ibytes[71:56]), 72'hF20A);
    chk("t1_valP", 72'(s_valp), 72'h0A);
    chk("t1_regids", 72'(s_regids), 72'd1);
    chk("t1_valC", 72'(s_valc), 72'd1);
    chk("t1_stat", 72'(s_stat), 72'd1);

    // rrmovq, halt
    fetch_directed(64'h10, 0, lat, nrd);
    chk("t2_ibytes", s_ibytes, {8'h12, 64'h0});
    chk("t2_valP", 72'(s_valp), 72'h12);
    chk("t2_nrd", 72'(nrd), 72'd2);
    fetch_directed(64'h20, 0, lat, nrd);
    chk("t2_halt_stat", 72'(s_stat), 72'd2);
    chk("t2_halt_valP", 72'(s_valp), 72'h21);
    chk("t2_halt_nrd", 72'(nrd), 72'd1);
    chk("t2_halt_lat", 72'(lat), 72'd3);

    // invalid icode, address error at end of memory
    fetch_directed(64'h30, 0, lat, nrd);
    chk("t3_ins_stat", 72'(s_stat), 72'd4);
    chk("t3_ins_valP", 72'(s_valp), 72'h31);
    chk("t3_ins_nrd", 72'(nrd), 72'd1);
    fetch_directed(64'h7FC, 0, lat, nrd);
    chk("t3_adr_stat", 72'(s_stat), 72'd3);
    chk("t3_adr_nrd", 72'(nrd), 72'd4);
    chk("t3_adr_valP", 72'(s_valp), 72'h806);
    chk("t3_adr_ibytes", s_ibytes, 72'hF2ABCD_000000000000);

    // backpressure for 5 cycles
    fetch_directed(64'h10, 5, lat, nrd);
    chk("t4_pc_ready_after", 72'(bus.pc_ready), 72'd1);

    // flush in A+5 of a 10-byte fetch
    @(posedge clk); #1;
    bus.pc = 64'h0;
    bus.pc_valid = 1'b1;
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_mem_rd", 72'(bus.mem_rd), 72'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("t5_idle_after", 72'(bus.pc_ready), 72'd1);
    repeat (12) @(posedge clk);
    #1 chk("t5_no_out_valid", 72'(bus.out_valid), 72'd0);
    fetch_directed(64'h10, 0, lat, nrd);
    chk("t5_valP", 72'(s_valp), 72'h12);

    // reset in A+4
    @(posedge clk); #1;
    bus.pc = 64'h0;
    bus.pc_valid = 1'b1;
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals();
    fetch_directed(64'h20, 0, lat, nrd);
    chk("t6_stat", 72'(s_stat), 72'd2);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 99);
      if (r < 75)      bus.pc = 64'($urandom_range(0, 2047));
      else if (r < 92) bus.pc = 64'(2048 - $urandom_range(1, 12));
      else             bus.pc = {$urandom, $urandom};
      bus.pc_valid = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    bus.pc_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
